// File: rtl/mem_access_pkg.sv
// Shared opcode, size and state definitions for the load/store stage,
// plus small decode helpers used by the top level.
package mem_access_pkg;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_ADDIU   = 6'h09,
    OP_LB      = 6'h20,
    OP_LH      = 6'h21,
    OP_LWL     = 6'h22,
    OP_LW      = 6'h23,
    OP_LBU     = 6'h24,
    OP_LHU     = 6'h25,
    OP_LWR     = 6'h26,
    OP_SB      = 6'h28,
    OP_SH      = 6'h29,
    OP_SW      = 6'h2B
  } opcode_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  function automatic logic is_load(input opcode_t op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input opcode_t op);
    case (op)
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic size_t op_size(input opcode_t op);
    case (op)
      OP_LH, OP_LHU, OP_SH:         return SZ_HALF;
      OP_LW, OP_SW, OP_LWL, OP_LWR: return SZ_WORD;
      default:                      return SZ_BYTE;
    endcase
  endfunction

  // LWL/LWR are unaligned by design and are exempt from the word check.
  function automatic logic is_misaligned(input opcode_t op, input logic [1:0] off);
    case (op_size(op))
      SZ_HALF: return off[0];
      SZ_WORD: return (op == OP_LWL || op == OP_LWR) ? 1'b0 : (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_extract.sv
// Combinational load extraction: byte/half/word selection with sign or zero
// extension, and the LWL/LWR merge with the old rt value.
module mem_load_extract
  import mem_access_pkg::*;
(
  input  opcode_t     opcode_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  input  logic [31:0] rt_i,
  output logic [31:0] rt_data_o
);

  logic [4:0]  rshift_s;
  logic [4:0]  lshift_s;
  logic [31:0] shifted_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] lwl_s;
  logic [31:0] lwr_s;

  // Lane selection and LWL/LWR merge terms; 3-n equals ~n for a 2-bit offset.
  always_comb begin
    rshift_s  = {offset_i, 3'b000};
    lshift_s  = {~offset_i, 3'b000};
    shifted_s = word_i >> rshift_s;
    byte_s    = shifted_s[7:0];
    half_s    = offset_i[1] ? word_i[31:16] : word_i[15:0];
    lwl_s     = (word_i << lshift_s) | (rt_i & ((32'h0000_0001 << lshift_s) - 32'h0000_0001));
    lwr_s     = shifted_s | (rt_i & ~(32'hFFFF_FFFF >> rshift_s));
  end

  // Final result mux by opcode.
  always_comb begin
    rt_data_o = 32'h0000_0000;
    case (opcode_i)
      OP_LB:   rt_data_o = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  rt_data_o = {24'h00_0000, byte_s};
      OP_LH:   rt_data_o = {{16{half_s[15]}}, half_s};
      OP_LHU:  rt_data_o = {16'h0000, half_s};
      OP_LW:   rt_data_o = word_i;
      OP_LWL:  rt_data_o = lwl_s;
      OP_LWR:  rt_data_o = lwr_s;
      default: rt_data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Load/store stage: one Avalon-style transaction per accepted request, with
// store lane steering, load extraction and a registered completion pulse.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int RESET_VECTOR_UNUSED = 0
)(
  input  logic        clk,
  input  logic        reset_i,
  input  logic        valid_i,
  input  opcode_t     opcode_i,
  input  logic [31:0] effective_address_i,
  input  logic [31:0] rt_i,
  output logic [31:0] mem_address_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [3:0]  mem_byteenable_o,
  output logic [31:0] mem_writedata_o,
  input  logic [31:0] mem_readdata_i,
  input  logic        mem_waitrequest_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fault_o,
  output logic        rt_we_o,
  output logic [31:0] rt_data_o
);

  logic unused_param_s;
  assign unused_param_s = (RESET_VECTOR_UNUSED != 0);

  mem_state_t  state_q, state_d;
  opcode_t     opcode_q, opcode_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] rt_q, rt_d;
  logic [31:0] addr_q, addr_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        rt_we_q, rt_we_d;
  logic [31:0] rt_data_q, rt_data_d;

  logic [3:0]  steer_be_s;
  logic [31:0] steer_data_s;
  logic [31:0] load_data_s;

  mem_load_extract u_extract (
    .opcode_i  (opcode_q),
    .offset_i  (ea_q[1:0]),
    .word_i    (mem_readdata_i),
    .rt_i      (rt_q),
    .rt_data_o (load_data_s)
  );

  // Store lane steering from the incoming request; loads enable every lane.
  always_comb begin
    steer_be_s   = 4'b1111;
    steer_data_s = 32'h0000_0000;
    case (opcode_i)
      OP_SB: begin
        steer_be_s   = 4'b0001 << effective_address_i[1:0];
        steer_data_s = {4{rt_i[7:0]}};
      end
      OP_SH: begin
        steer_be_s   = effective_address_i[1] ? 4'b1100 : 4'b0011;
        steer_data_s = {2{rt_i[15:0]}};
      end
      OP_SW: begin
        steer_be_s   = 4'b1111;
        steer_data_s = rt_i;
      end
      default: begin
        steer_be_s   = 4'b1111;
        steer_data_s = 32'h0000_0000;
      end
    endcase
  end

  // Next-state and next-output logic; outputs are precomputed so they register cleanly.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    ea_d      = ea_q;
    rt_d      = rt_q;
    addr_d    = 32'h0000_0000;
    read_d    = 1'b0;
    write_d   = 1'b0;
    be_d      = 4'b0000;
    wdata_d   = 32'h0000_0000;
    done_d    = 1'b0;
    fault_d   = 1'b0;
    rt_we_d   = 1'b0;
    rt_data_d = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        if (valid_i && (is_load(opcode_i) || is_store(opcode_i))) begin
          opcode_d = opcode_i;
          ea_d     = effective_address_i;
          rt_d     = rt_i;
          if (is_misaligned(opcode_i, effective_address_i[1:0])) begin
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d = ACCESS;
            addr_d  = {effective_address_i[31:2], 2'b00};
            read_d  = is_load(opcode_i);
            write_d = is_store(opcode_i);
            be_d    = steer_be_s;
            wdata_d = steer_data_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (mem_waitrequest_i) begin
          addr_d  = addr_q;
          read_d  = read_q;
          write_d = write_q;
          be_d    = be_q;
          wdata_d = wdata_q;
        end else begin
          state_d   = DONE;
          done_d    = 1'b1;
          rt_we_d   = is_load(opcode_q);
          rt_data_d = is_load(opcode_q) ? load_data_s : 32'h0000_0000;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q   <= IDLE;
      opcode_q  <= OP_SPECIAL;
      ea_q      <= 32'h0000_0000;
      rt_q      <= 32'h0000_0000;
      addr_q    <= 32'h0000_0000;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      be_q      <= 4'b0000;
      wdata_q   <= 32'h0000_0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      rt_we_q   <= 1'b0;
      rt_data_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      ea_q      <= ea_d;
      rt_q      <= rt_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
      write_q   <= write_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
      rt_we_q   <= rt_we_d;
      rt_data_q <= rt_data_d;
    end
  end

  assign mem_address_o    = addr_q;
  assign mem_read_o       = read_q;
  assign mem_write_o      = write_q;
  assign mem_byteenable_o = be_q;
  assign mem_writedata_o  = wdata_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign fault_o          = fault_q;
  assign rt_we_o          = rt_we_q;
  assign rt_data_o        = rt_data_q;

endmodule
